// File: rtl/serial_sub16.sv
// serial_sub16: bit-serial two's-complement subtractor, D = A - B - Bin.
// One full-adder slice per cycle computes A + ~B + ~Bin LSB-first with a
// registered carry. Start/done handshake; the result is held until the
// next accepted start completes.
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  // Full-adder slice on the current LSBs; the subtrahend bit is inverted.
  logic bit_a, bit_nb, sum_bit, carry_out, last;
  assign bit_a     = a_sr[0];
  assign bit_nb    = ~b_sr[0];
  assign sum_bit   = bit_a ^ bit_nb ^ carry;
  assign carry_out = (bit_a & bit_nb) | (bit_a & carry) | (bit_nb & carry);
  assign last      = (cnt == LAST_BIT);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs, regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept start only when idle, leave RUN after the MSB.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last)  state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  // Output logic: busy is purely a function of the state.
  always_comb begin
    busy = (state == RUN);
  end

  // Datapath: operand capture, one bit per cycle, result and done update.
  // NOTE: the shift registers are plain flops, not a memory, so they are
  // cleared on reset together with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      D       <= '0;
      Bout    <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sr  <= A;
          b_sr  <= B;
          carry <= ~Bin;
          cnt   <= '0;
        end
      end else begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        diff_sr <= {sum_bit, diff_sr[WIDTH-1:1]};
        carry   <= carry_out;
        cnt     <= cnt + CNT_W'(1);
        if (last) begin
          // carry currently holds the carry into the MSB slice.
          D    <= {sum_bit, diff_sr[WIDTH-1:1]};
          Bout <= ~carry_out;
          ovf  <= carry ^ carry_out;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16: directed and random checks of the bit-serial subtractor.
module tb_serial_sub16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A, B;
  logic        Bin;
  logic [15:0] D;
  logic        Bout, ovf, busy, done;

  int checks = 0;
  int errors = 0;

  serial_sub16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .D(D), .Bout(Bout), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {~Bout, D} = A + ~B + ~Bin; signed overflow from operand signs.
  task automatic model(input logic [15:0] a, b, input logic bin,
                       output logic [15:0] d, output logic bo, output logic ov);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, ~b} + {16'd0, ~bin};
    d   = sum[15:0];
    bo  = ~sum[16];
    ov  = (a[15] != b[15]) && (d[15] != a[15]);
  endtask

  // Waits (from the negedge after the start edge, k=0) for done.
  // lat = negedges until done seen (-1 on timeout); also counts busy cycles
  // and whether D moved before done.
  task automatic wait_done(output int lat, output int busy_cyc, output bit d_moved);
    logic [15:0] d0;
    d0 = D; lat = -1; busy_cyc = 0; d_moved = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin lat = k; break; end
      if (busy) busy_cyc++;
      if (D !== d0) d_moved = 1'b1;
      @(negedge clk);
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Issue one op with a single-cycle start; returns at the done negedge.
  task automatic do_op(input logic [15:0] a, b, input logic bin,
                       output int lat, output int busy_cyc, output bit d_moved);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; Bin = ~bin;  // changes after capture must not matter
    wait_done(lat, busy_cyc, d_moved);
  endtask

  task automatic check_result(input string tag, input logic [15:0] ed,
                              input logic eb, input logic eo);
    check({tag, "_D"}, {16'd0, D}, {16'd0, ed});
    check({tag, "_Bout"}, {31'd0, Bout}, {31'd0, eb});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    int lat, bc, gap, ndone;
    bit dm;
    logic [15:0] ra, rb, ed;
    logic rbin, eb, eo;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_D", {16'd0, D}, 32'd0);
    check("rst_flags", {29'd0, Bout, ovf, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 1. basic op with latency and busy width
    do_op(16'h1234, 16'h0234, 1'b0, lat, bc, dm);
    check("t1_latency", lat, 32'd16);
    check("t1_busy_cycles", bc, 32'd16);
    check("t1_D_stable", {31'd0, dm}, 32'd0);
    check_result("t1", 16'h1000, 1'b0, 1'b0);
    check("t1_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_hold_D", {16'd0, D}, 32'h1000);

    // 2. borrow cases
    do_op(16'h0000, 16'h0001, 1'b0, lat, bc, dm);
    check_result("t2a", 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    do_op(16'h0005, 16'h0005, 1'b1, lat, bc, dm);
    check_result("t2b", 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);

    // 3. signed overflow cases
    do_op(16'h8000, 16'h0001, 1'b0, lat, bc, dm);
    check_result("t3a", 16'h7FFF, 1'b0, 1'b1);
    @(negedge clk);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, lat, bc, dm);
    check_result("t3b", 16'h8000, 1'b1, 1'b1);
    @(negedge clk);
    do_op(16'h0000, 16'hFFFF, 1'b1, lat, bc, dm);   // B=max with Bin=1
    check_result("t3c", 16'h0000, 1'b1, 1'b0);
    @(negedge clk);

    // 4a. start re-pulsed mid-run with new operands is ignored
    A = 16'h0100; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    A = 16'hFFFF; B = 16'h1111; Bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc, dm);
    check("t4a_latency", lat, 32'd10);  // 6 negedges already consumed
    check_result("t4a", 16'h00FF, 1'b0, 1'b0);
    @(negedge clk);
    check("t4a_no_requeue", {30'd0, busy, done}, 32'd0);

    // 4b. start held through the done cycle: back-to-back second op
    A = 16'h0003; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 16'h1000; B = 16'h2000; Bin = 1'b1;   // second op operands
    wait_done(lat, bc, dm);
    check("t4b_first_latency", lat, 32'd16);
    check_result("t4b_first", 16'h0002, 1'b0, 1'b0);
    @(negedge clk);                           // start sampled at this edge
    start = 1'b0;
    check("t4b_second_busy", {31'd0, busy}, 32'd1);
    wait_done(lat, bc, dm);
    check("t4b_second_latency", lat, 32'd16);
    check_result("t4b_second", 16'hEFFF, 1'b1, 1'b0);
    @(negedge clk);

    // 5. async reset mid-run
    A = 16'h4321; B = 16'h1234; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_D", {16'd0, D}, 32'd0);
    check("t5_rst_flags", {29'd0, Bout, ovf, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("t5_no_done", ndone, 32'd0);

    // 6. random ops with random idle gaps
    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (n == 0) begin ra = 16'h0000; rb = 16'hFFFF; rbin = 1'b1; end
      model(ra, rb, rbin, ed, eb, eo);
      do_op(ra, rb, rbin, lat, bc, dm);
      if (lat != 16) check("t6_latency", lat, 32'd16);
      check_result($sformatf("t6_%0d", n), ed, eb, eo);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(negedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
